// File: rtl/cmul_rr_scheduler.sv
// Round-robin front end sharing one complex_matrix_mul datapath between NUM_REQ clients.
// Optional per-requester grant counters are enabled by defining CMUL_SCHED_PERF_EN.
module cmul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int SIZE    = 16,
    parameter int DEPTH   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*SIZE*4*WIDTH-1:0]   req_operands_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    input  logic [NUM_REQ-1:0]                rsp_ready_i,
    output logic [2*SIZE*WIDTH-1:0]           rsp_result_o,
    output logic                              dp_in_valid_o,
    input  logic                              dp_in_ready_i,
    output logic [SIZE*4*WIDTH-1:0]           dp_operands_o,
    output logic                              dp_flush_o,
    input  logic                              dp_out_valid_i,
    output logic                              dp_out_ready_o,
    input  logic [2*SIZE*WIDTH-1:0]           dp_result_i,
    input  logic                              dp_busy_i,
    output logic                              busy_o
`ifdef CMUL_SCHED_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]             perf_grant_o
`endif
);

    localparam int OPW = SIZE * 4 * WIDTH;
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [IDW-1:0] ptr_reg;
    logic           iss_vld_reg;
    logic [OPW-1:0] iss_data_reg;
    logic [IDW-1:0] tag_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  cnt_reg;

    logic [OPW-1:0] req_ops [NUM_REQ];
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           can_accept;
    logic           accept;
    logic           has_work;
    logic [IDW-1:0] head;
    logic           pop;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ops
        assign req_ops[gi] = req_operands_i[gi*OPW +: OPW];
    end

    // Walk offsets from the highest down so the lowest offset from ptr wins.
    always_comb begin
        logic [IDW-1:0] pos;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = IDW'((int'(ptr_reg) + k) % NUM_REQ);
            if (req_valid_i[pos]) begin
                grant_any = 1'b1;
                grant_idx = pos;
            end
        end
    end

    // Space check uses the registered count: a same-cycle pop never frees a slot.
    assign can_accept = (!iss_vld_reg || dp_in_ready_i) && (cnt_reg < CW'(DEPTH))
                        && !flush_i && !rst_i;
    assign accept     = grant_any && can_accept;
    assign has_work   = (cnt_reg != '0);
    assign head       = tag_mem[rd_ptr_reg];
    assign pop        = dp_out_valid_i && has_work && rsp_ready_i[head] && !flush_i;

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_hs
        assign req_ready_o[gi] = accept && (grant_idx == IDW'(gi));
        assign rsp_valid_o[gi] = dp_out_valid_i && has_work && !flush_i && (head == IDW'(gi));
    end

    // With nothing tracked (or during flush) results are sunk so the datapath never stalls.
    assign dp_out_ready_o = !rst_i && (flush_i || !has_work || rsp_ready_i[head]);
    assign rsp_result_o   = dp_result_i;
    assign dp_in_valid_o  = iss_vld_reg;
    assign dp_operands_o  = iss_data_reg;
    assign dp_flush_o     = flush_i;
    assign busy_o         = !rst_i && (iss_vld_reg || has_work || dp_busy_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg      <= '0;
            iss_vld_reg  <= 1'b0;
            iss_data_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
        end else if (flush_i) begin
            ptr_reg      <= '0;
            iss_vld_reg  <= 1'b0;
            iss_data_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
        end else begin
            if (accept) begin
                iss_vld_reg  <= 1'b1;
                iss_data_reg <= req_ops[grant_idx];
                ptr_reg      <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
            end else if (dp_in_ready_i) begin
                iss_vld_reg  <= 1'b0;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            cnt_reg <= cnt_reg + CW'(accept) - CW'(pop);
        end
    end

    // Tag storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

`ifdef CMUL_SCHED_PERF_EN
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [15:0] count_reg;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                count_reg <= '0;
            end else if (flush_i) begin
                count_reg <= '0;
            end else if (req_ready_o[gi] && req_valid_i[gi] && count_reg != 16'hFFFF) begin
                count_reg <= count_reg + 16'd1;
            end
        end
        assign perf_grant_o[gi*16 +: 16] = count_reg;
    end
`endif

endmodule

// File: tb/tb_cmul_rr_scheduler.sv
// Bench for cmul_rr_scheduler: queue-based reference model plus a zero-latency datapath stand-in.
module tb_cmul_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int S  = 16;
    localparam int D  = 4;
    localparam int OW = S * 4 * W;
    localparam int RW = 2 * S * W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*OW-1:0] req_operands;
    logic [OW-1:0]  ops [N];
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [RW-1:0]  rsp_result;
    logic           dp_in_valid;
    logic           dp_in_rdy = 1'b1;
    logic [OW-1:0]  dp_operands;
    logic           dp_flush;
    logic           dp_vld = 1'b0;
    logic           stray = 1'b0;
    logic           dp_out_valid;
    logic           dp_out_ready;
    logic [RW-1:0]  dp_result = '0;
    logic           dp_busy = 1'b0;
    logic           dp_out_en = 1'b1;
    logic           busy;

    int errors = 0;
    int checks = 0;

    assign dp_out_valid = dp_vld | stray;
    always #5 clk = ~clk;

    always_comb begin
        req_operands = '0;
        for (int i = 0; i < N; i++) req_operands[i*OW +: OW] = ops[i];
    end

    cmul_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .SIZE(S), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .dp_in_valid_o(dp_in_valid), .dp_in_ready_i(dp_in_rdy), .dp_operands_o(dp_operands),
        .dp_flush_o(dp_flush), .dp_out_valid_i(dp_out_valid), .dp_out_ready_o(dp_out_ready),
        .dp_result_i(dp_result), .dp_busy_i(dp_busy), .busy_o(busy)
    );

    // Lane l: words {ar, ai, br, bi}; result words {re, im} of (ar + j*ai) * (br + j*bi).
    function automatic logic [RW-1:0] cmul(input logic [OW-1:0] o);
        logic [RW-1:0] r;
        real ar, ai, br, bi;
        r = '0;
        for (int l = 0; l < S; l++) begin
            ar = $bitstoreal(o[(l*4+0)*W +: W]);
            ai = $bitstoreal(o[(l*4+1)*W +: W]);
            br = $bitstoreal(o[(l*4+2)*W +: W]);
            bi = $bitstoreal(o[(l*4+3)*W +: W]);
            r[(2*l)*W +: W]   = $realtobits(ar * br - ai * bi);
            r[(2*l+1)*W +: W] = $realtobits(ar * bi + ai * br);
        end
        return r;
    endfunction

    // Datapath stand-in: in-order results one edge after the input handshake.
    logic [RW-1:0] dpq [$];
    always @(posedge clk) begin
        if (rst || dp_flush) begin
            dpq.delete();
        end else begin
            if (dp_out_valid && dp_out_ready && dpq.size() > 0) void'(dpq.pop_front());
            if (dp_in_valid && dp_in_rdy) dpq.push_back(cmul(dp_operands));
        end
        dp_vld    <= dp_out_en && (dpq.size() > 0);
        dp_result <= (dpq.size() > 0) ? dpq[0] : '0;
        dp_busy   <= (dpq.size() > 0);
    end

    // Reference model: rotating pointer, ordered list of outstanding owners and their results.
    int            m_ptr = 0;
    int            m_ids [$];
    logic [RW-1:0] m_res [$];
    bit            m_iss = 1'b0;
    logic [OW-1:0] m_iss_data = '0;

    function automatic int m_winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_winner();
        if (g >= 0 && !rst && !flush && (!m_iss || dp_in_rdy) && m_ids.size() < D) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] exp_rsp();
        logic [N-1:0] r;
        r = '0;
        if (!rst && !flush && dp_out_valid && m_ids.size() > 0) r[m_ids[0]] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_oready();
        if (rst) return 1'b0;
        if (flush || m_ids.size() == 0) return 1'b1;
        return rsp_ready[m_ids[0]];
    endfunction

    always @(posedge clk) begin
        int g;
        bit acc;
        bit pop;
        if (rst || flush) begin
            m_ptr = 0;
            m_ids.delete();
            m_res.delete();
            m_iss = 1'b0;
        end else begin
            g   = m_winner();
            acc = (exp_ready() != '0);
            pop = 1'b0;
            if (dp_out_valid && m_ids.size() > 0) pop = rsp_ready[m_ids[0]];
            if (pop) begin
                void'(m_ids.pop_front());
                void'(m_res.pop_front());
            end
            if (acc) begin
                m_ids.push_back(g);
                m_res.push_back(cmul(ops[g]));
                m_ptr      = (g + 1) % N;
                m_iss      = 1'b1;
                m_iss_data = ops[g];
            end else if (m_iss && dp_in_rdy) begin
                m_iss = 1'b0;
            end
        end
    end

    task automatic randomize_ops();
        for (int i = 0; i < N; i++)
            for (int w = 0; w < S * 4; w++)
                ops[i][w*W +: W] = $realtobits(real'($urandom_range(0, 9)) - 4.0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; stray = 1'b0; req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = '1; rsp_ready = '1; #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (dp_in_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_in_valid got=%b exp=0", dp_in_valid); end
        checks++; if (dp_out_ready !== 1'b0) begin errors++; $display("FAIL reset_dp_out_ready got=%b exp=0", dp_out_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dp_operands !== '0) begin errors++; $display("FAIL reset_dp_operands nonzero"); end
        req_valid = '0; rsp_ready = '0;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        ops[0] = '0;
        ops[0][0*W +: W] = 64'h401C000000000000;
        ops[0][1*W +: W] = 64'h4000000000000000;
        ops[0][2*W +: W] = 64'h3FF0000000000000;
        ops[0][3*W +: W] = 64'h4000000000000000;
        rsp_ready = '1; dp_in_rdy = 1'b1; dp_out_en = 1'b1; req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0; #1;
        checks++; if (dp_in_valid !== 1'b1) begin errors++; $display("FAIL single_issue_latency got=%b exp=1", dp_in_valid); end
        checks++; if (dp_operands !== ops[0]) begin errors++; $display("FAIL single_dp_operands mismatched bundle"); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
        checks++; if (rsp_result[0 +: W] !== 64'h4008000000000000) begin errors++; $display("FAIL single_re got=%h exp=4008000000000000", rsp_result[0 +: W]); end
        checks++; if (rsp_result[W +: W] !== 64'h4030000000000000) begin errors++; $display("FAIL single_im got=%h exp=4030000000000000", rsp_result[W +: W]); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq [5];
        int rsp_idx;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rsp_idx = 0;
        do_reset();
        randomize_ops();
        req_valid = '1; rsp_ready = '1; dp_in_rdy = 1'b1; dp_out_en = 1'b1; #1;
        for (int c = 0; c < 12; c++) begin
            if (c < 5) begin
                checks++; if (req_ready !== seq[c]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", c, req_ready, seq[c]); end
            end
            checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rr_ready got=%b exp=%b", req_ready, exp_ready()); end
            checks++; if (rsp_valid !== exp_rsp()) begin errors++; $display("FAIL rr_rsp_valid got=%b exp=%b", rsp_valid, exp_rsp()); end
            if (rsp_valid !== '0 && rsp_idx < 4) begin
                checks++; if (rsp_valid !== seq[rsp_idx]) begin errors++; $display("FAIL rr_rsp_order%0d got=%b exp=%b", rsp_idx, rsp_valid, seq[rsp_idx]); end
                rsp_idx++;
            end
            if (exp_rsp() !== '0) begin
                checks++; if (rsp_result !== m_res[0]) begin errors++; $display("FAIL rr_result wrong data for tag %0d", m_ids[0]); end
            end
            @(negedge clk);
            randomize_ops(); #1;
        end
        checks++; if (rsp_idx !== 4) begin errors++; $display("FAIL rr_rsp_count got=%0d exp=4", rsp_idx); end
        req_valid = '0;
    endtask

    task automatic test_out_stall();
        int n_acc;
        n_acc = 0;
        do_reset();
        randomize_ops();
        rsp_ready = '0; dp_in_rdy = 1'b1; dp_out_en = 1'b1; req_valid = 4'b0001; #1;
        for (int c = 0; c < 8; c++) begin
            checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL stall_ready got=%b exp=%b", req_ready, exp_ready()); end
            if (req_ready[0]) n_acc++;
            @(negedge clk); #1;
        end
        checks++; if (n_acc !== 4) begin errors++; $display("FAIL stall_accepts got=%0d exp=4", n_acc); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_held got=%b exp=0000", req_ready); end
        rsp_ready = 4'b0001; #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL stall_head got=%b exp=0001", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_same_cycle_pop got=%b exp=0000", req_ready); end
        @(negedge clk);
        rsp_ready = '0; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_release got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0; rsp_ready = '1;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_in_stall();
        do_reset();
        randomize_ops();
        dp_in_rdy = 1'b0; rsp_ready = '1; req_valid = N'($urandom_range(1, 15)); #1;
        checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL install_first got=%b exp=%b", req_ready, exp_ready()); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            randomize_ops();
            req_valid = N'($urandom_range(1, 15)); #1;
            checks++; if (dp_operands !== m_iss_data) begin errors++; $display("FAIL install_stable cycle %0d operands changed", c); end
            checks++; if (req_ready !== '0 || dp_in_valid !== 1'b1) begin errors++; $display("FAIL install_block got ready=%b vld=%b exp 0000/1", req_ready, dp_in_valid); end
        end
        req_valid = '0; dp_in_rdy = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_flush();
        do_reset();
        randomize_ops();
        dp_in_rdy = 1'b1; rsp_ready = '0; dp_out_en = 1'b1; req_valid = 4'b0010; #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL flush_fill%0d got=%b exp=0010", c, req_ready); end
            @(negedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
        flush = 1'b1; req_valid = '1; #1;
        checks++; if (dp_flush !== 1'b1) begin errors++; $display("FAIL flush_pulse got=%b exp=1", dp_flush); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL flush_rsp got=%b exp=0000", rsp_valid); end
        checks++; if (dp_out_ready !== 1'b1) begin errors++; $display("FAIL flush_sink got=%b exp=1", dp_out_ready); end
        @(negedge clk);
        flush = 1'b0; req_valid = '0; #1;
        checks++; if (dp_flush !== 1'b0) begin errors++; $display("FAIL flush_end got=%b exp=0", dp_flush); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        stray = 1'b1; #1;
        checks++; if (dp_out_ready !== 1'b1 || rsp_valid !== '0) begin errors++; $display("FAIL flush_stray got rdy=%b rsp=%b exp 1/0000", dp_out_ready, rsp_valid); end
        @(negedge clk);
        stray = 1'b0; req_valid = '1; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr got=%b exp=0001", req_ready); end
        req_valid = '0; rsp_ready = '1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        randomize_ops();
        req_valid = '1; dp_in_rdy = 1'b1; dp_out_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rsp_ready = N'($urandom);
            @(negedge clk);
        end
        rst = 1'b1; #1;
        checks++; if (req_ready !== '0 || rsp_valid !== '0) begin errors++; $display("FAIL rstmid_hs got ready=%b rsp=%b exp 0", req_ready, rsp_valid); end
        checks++; if (dp_in_valid !== 1'b0 || dp_out_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got in=%b out=%b busy=%b exp 0", dp_in_valid, dp_out_ready, busy); end
        checks++; if (dp_operands !== '0) begin errors++; $display("FAIL rstmid_operands nonzero"); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_grant got=%b exp=0001", req_ready); end
        req_valid = '0; rsp_ready = '1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            randomize_ops();
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            dp_in_rdy = ($urandom_range(0, 3) != 0);
            dp_out_en = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
            checks++; if (rsp_valid !== exp_rsp()) begin errors++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp()); end
            if (exp_rsp() !== '0) begin
                checks++; if (rsp_result !== m_res[0]) begin errors++; $display("FAIL rnd_result c=%0d wrong data for tag %0d", c, m_ids[0]); end
            end
            checks++; if (dp_in_valid !== m_iss) begin errors++; $display("FAIL rnd_in_valid c=%0d got=%b exp=%b", c, dp_in_valid, m_iss); end
            if (m_iss) begin
                checks++; if (dp_operands !== m_iss_data) begin errors++; $display("FAIL rnd_operands c=%0d mismatched bundle", c); end
            end
            checks++; if (busy !== (m_iss || m_ids.size() > 0 || dp_busy)) begin errors++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
            if (flush || dp_out_valid || m_ids.size() > 0) begin
                checks++; if (dp_out_ready !== exp_oready()) begin errors++; $display("FAIL rnd_out_ready c=%0d got=%b exp=%b", c, dp_out_ready, exp_oready()); end
            end
            @(negedge clk);
        end
        flush = 1'b0; req_valid = '0;
    endtask

    initial begin
        randomize_ops();
        test_reset();
        test_single();
        test_round_robin();
        test_out_stall();
        test_in_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
